// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package addsub_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} addsub_op_t;

  // Widest result sat_value can build; callers truncate to their own width.
  localparam int SAT_MAX_W = 128;

  // Clamp value for a signed overflow: max-positive when neg=0, min-negative when neg=1.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input logic neg, input int n);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < n - 1) v[i] = ~neg;
      else if (i == n - 1) v[i] = neg;
    end
    return v;
  endfunction

endpackage

// File: rtl/addsub_segment.sv
// Combinational W-bit ripple slice; b is inverted when op=1 so subtraction reuses the adder.
module addsub_segment #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] c;

  always_comb begin
    logic bb;
    c    = '0;
    sum  = '0;
    bb   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      bb       = b[i] ^ op;
      sum[i]   = a[i] ^ bb ^ c[i];
      c[i+1]   = (a[i] & bb) | (c[i] & (a[i] ^ bb));
    end
  end

  assign cout     = c[W];
  // Carry into the top bit; XOR with cout gives signed overflow in the last segment.
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// N-bit adder/subtractor with the carry chain cut into STAGES registered ripple segments.
// Handshake: a beat moves in on in_valid && in_ready and out on out_valid && out_ready;
// every stage shifts together on advance = !out_valid || out_ready, and in_ready = advance.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  input  logic         sat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  // N must be a multiple of STAGES.
  localparam int W   = N / STAGES;
  localparam int TOP = STAGES - 1;
  localparam int NR  = (STAGES > 1) ? STAGES - 1 : 1;
  localparam logic [N-1:0] SEG_MASK = N'({W{1'b1}});

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage inputs: operands with the already-computed low segments folded into sx.
  logic [N-1:0] sx    [STAGES];
  logic [N-1:0] sy    [STAGES];
  addsub_op_t   sop   [STAGES];
  logic         ssat  [STAGES];
  logic         scin  [STAGES];
  logic         sv    [STAGES];

  logic [W-1:0] sum      [STAGES];
  logic         seg_cout [STAGES];
  logic         seg_cmsb [STAGES];

  // Inter-stage registers (stage TOP feeds the output register instead).
  logic [N-1:0] rx   [NR];
  logic [N-1:0] ry   [NR];
  addsub_op_t   rop  [NR];
  logic         rsat [NR];
  logic         rc   [NR];
  logic         rv   [NR];
  logic [N-1:0] mx   [NR];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign sx[k]   = a;
      assign sy[k]   = b;
      assign sop[k]  = addsub_op_t'(op);
      assign ssat[k] = sat;
      assign scin[k] = op;
      assign sv[k]   = in_valid;
    end else begin : g_next
      assign sx[k]   = rx[k-1];
      assign sy[k]   = ry[k-1];
      assign sop[k]  = rop[k-1];
      assign ssat[k] = rsat[k-1];
      assign scin[k] = rc[k-1];
      assign sv[k]   = rv[k-1];
    end

    addsub_segment #(.W(W)) u_seg (
      .a        (sx[k][k*W +: W]),
      .b        (sy[k][k*W +: W]),
      .op       (sop[k] == OP_SUB),
      .cin      (scin[k]),
      .sum      (sum[k]),
      .cout     (seg_cout[k]),
      .c_msb_in (seg_cmsb[k])
    );

    if (k < TOP) begin : g_merge
      assign mx[k] = (sx[k] & ~(SEG_MASK << (k*W))) | (N'(sum[k]) << (k*W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NR; k++) begin
        rv[k]   <= 1'b0;
        rx[k]   <= '0;
        ry[k]   <= '0;
        rop[k]  <= OP_ADD;
        rsat[k] <= 1'b0;
        rc[k]   <= 1'b0;
      end
    end else if (advance) begin
      // Bubbles shift along with real beats; nothing is compressed.
      for (int k = 0; k < TOP; k++) begin
        rv[k]   <= sv[k];
        rx[k]   <= mx[k];
        ry[k]   <= sy[k];
        rop[k]  <= sop[k];
        rsat[k] <= ssat[k];
        rc[k]   <= seg_cout[k];
      end
    end
  end

  // Last segment: overflow, optional clamp toward the sign of a, then zero on the final value.
  logic [N-1:0] raw;
  logic [N-1:0] fin;
  logic         fin_ovf;

  assign raw     = (sx[TOP] & ~(SEG_MASK << (TOP*W))) | (N'(sum[TOP]) << (TOP*W));
  assign fin_ovf = seg_cmsb[TOP] ^ seg_cout[TOP];
  assign fin     = (ssat[TOP] && fin_ovf) ? N'(sat_value(sx[TOP][N-1], N)) : raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      out_valid <= sv[TOP];
      result    <= fin;
      cout      <= seg_cout[TOP];
      ovf       <= fin_ovf;
      zero      <= (fin == '0);
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed spec cases, backpressure, reset mid-flight, random traffic.
module tb_pipelined_addsub;

  localparam int N      = 32;
  localparam int STAGES = 4;
  localparam int EW     = N + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         op;
  logic         sat;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic lat_strict = 1'b0;

  // Expected {result, cout, ovf, zero} per accepted beat, plus its acceptance cycle.
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];

  pipelined_addsub #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                          input logic mop, input logic msat);
    logic [N:0]   full;
    longint       sa, sb, sr, maxp, minn;
    logic         v;
    logic [N-1:0] r;
    maxp = (longint'(1) <<< (N - 1)) - 1;
    minn = -(longint'(1) <<< (N - 1));
    sa   = longint'($signed(ma));
    sb   = longint'($signed(mb));
    if (mop) begin
      full = {1'b0, ma} + {1'b0, ~mb} + (N+1)'(1);
      sr   = sa - sb;
    end else begin
      full = {1'b0, ma} + {1'b0, mb};
      sr   = sa + sb;
    end
    v = (sr > maxp) || (sr < minn);
    r = full[N-1:0];
    if (msat && v) r = (sr > 0) ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
    return {r, full[N], v, (r == '0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_exp(input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic top, input logic tsat, input logic [EW-1:0] want);
    int guard;
    guard = 0;
    @(negedge clk);
    a = ta; b = tb; op = top; sat = tsat; in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout in_ready=%0b expected=1", in_ready);
    end else begin
      exp_q.push_back(want);
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb,
                      input logic top, input logic tsat);
    send_exp(ta, tb, top, tsat, model(ta, tb, top, tsat));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [N-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(N-1){1'b1}}};
      3:       return {1'b1, {(N-1){1'b0}}};
      4:       return N'($urandom_range(0, 15));
      default: return N'($urandom);
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [EW:0]   held;
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    logic          was_stalled;
    int            c0;
    was_stalled = 1'b0;
    held        = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        was_stalled = 1'b0;
        continue;
      end
      if (was_stalled) chk("hold_while_stalled", 64'({out_valid, result, cout, ovf, zero}), 64'(held));
      if (out_valid && out_ready) begin
        got = {result, cout, ovf, zero};
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(got), 64'd0);
          if (got == '0) begin
            errors++;
            $display("FAIL unexpected_beat got=%h expected=no beat", got);
          end
        end else begin
          want = exp_q.pop_front();
          c0   = acc_q.pop_front();
          chk("beat", 64'(got), 64'(want));
          if (lat_strict) chk("latency", 64'(cyc - c0), 64'(STAGES));
        end
      end
      was_stalled = out_valid && !out_ready;
      if (was_stalled) begin
        held = {out_valid, result, cout, ovf, zero};
        chk("in_ready_stall", 64'(in_ready), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic rand_done;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; sat = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({out_valid, result, cout, ovf, zero}), 64'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed cases with spec-given answers, back to back, no backpressure.
    lat_strict = 1'b1;
    send_exp(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_0100, 1'b0, 1'b0, 1'b0});
    send_exp(32'd5,         32'd7,         1'b1, 1'b0, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    send_exp(32'd7,         32'd5,         1'b1, 1'b0, {32'h0000_0002, 1'b1, 1'b0, 1'b0});
    send_exp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
    send_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
    send_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    send_exp(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, {32'h8000_0000, 1'b1, 1'b1, 1'b0});
    send_exp(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
    send_exp(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, {32'h8000_0000, 1'b1, 1'b1, 1'b0});
    drain();

    // Backpressure: 8 back-to-back beats, out_ready low for three cycles mid-stream.
    lat_strict = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight: none may emerge.
    lat_strict = 1'b1;
    for (int i = 0; i < 3; i++) send(N'($urandom), N'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midflight_reset_outputs", 64'({out_valid, result, cout, ovf, zero}), 64'd0);
    chk("midflight_reset_in_ready", 64'(in_ready), 64'd1);
    repeat (6) @(negedge clk);
    send(32'h1234_5678, 32'h0000_1111, 1'b1, 1'b0);
    drain();

    // Random traffic with random backpressure.
    lat_strict = 1'b0;
    rand_done  = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 4) == 0) @(negedge clk);
          send(rnd_operand(), rnd_operand(), 1'($urandom), 1'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the N-bit ripple adder/subtractor used by the Radix-4 multiplier datapath.
- Splits the N-bit carry chain into STAGES registered segments. Each segment is a ripple slice, and the carry is registered between segments.
- Adds a valid/ready handshake with backpressure, signed overflow and zero flags, and an optional signed saturation mode.
- Sits between the partial-product generator and the accumulator, where a single-cycle 32/64-bit ripple chain misses timing.

Parameters:
- N, 32, operand/result width in bits.
- STAGES, 4, number of pipeline segments; N % STAGES must equal 0; 1 ≤ STAGES ≤ N.
- W, N/STAGES (localparam), segment width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- op  in  1  0 = A+B, 1 = A−B (B inverted, carry-in = 1).
- sat  in  1  1 = clamp result to the signed range on overflow.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- result  out  N  sum/difference, saturated if requested.
- cout  out  1  carry out of bit N−1. For subtraction, 1 = no borrow.
- ovf  out  1  signed overflow, reported before saturation.
- zero  out  1  final result == 0.

Behaviour:
- **Reset.** Synchronous: on a clk edge with rst=1, all stage valid bits are cleared and out_valid, result, cout, ovf and zero are driven to 0. Data in flight is discarded, with no partial output. in_ready is 1 in the first cycle after reset.
- **Transfer rules.**
  - An input beat is accepted when in_valid && in_ready.
  - An output beat is consumed when out_valid && out_ready.
- **Stall.** Global stall with a single enable: advance = !out_valid || out_ready, and in_ready = advance.
  - All stages shift together when advance=1 and hold otherwise. Bubbles are not compressed.
  - in_ready depends combinationally on out_ready only; there is no combinational path from in_valid to in_ready.
- **Stage k (0..STAGES−1)** computes bits [k·W +: W]:
  - carry-in = op for k=0, otherwise the registered carry from stage k−1;
  - operand bit = b ^ op;
  - then registers that slice together with the pass-through upper operand segments, op, sat, and the lower result segments.
- **Latency.** Exactly STAGES cycles from acceptance to out_valid when unstalled. Throughput is 1 beat/cycle.
- **Ordering.** Results emerge in acceptance order. op and sat travel with their beat, so per-beat mode changes are legal.
- **Final stage** computes, combinationally before the output register:
  - cout = carry out of bit N−1;
  - ovf = carry into bit N−1 XOR carry out of bit N−1;
  - if sat && ovf: result = {1'b0,{N−1{1'b1}}} when a[N−1]==0, else {1'b1,{N−1{1'b0}}};
  - zero = (result == 0), evaluated after saturation.
- **Output hold.** Outputs are held stable while out_valid && !out_ready.
- **Simultaneous events.**
  - A full pipeline with out_ready=1 and in_valid=1 accepts and emits in the same cycle.
  - rst has priority over every handshake.
- **STAGES=1** degenerates to a registered single-cycle adder/subtractor with the same handshake.

Decomposition:
- Package addsub_pkg:
  - typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} addsub_op_t;
  - function sat_value(sign, N-bit) returning the max-positive or min-negative constant.
- Sub-module addsub_segment #(W): combinational W-bit ripple slice.
  - Inputs: a, b, op, cin.
  - Outputs: sum, cout, and c_msb_in (the carry into its top bit, used for ovf in the last segment).
  - Instantiated STAGES times in a generate loop.

Test Plan:
- N=32, STAGES=4, out_ready=1: add 0x0000_00FF + 0x0000_0001 -> after 4 cycles result=0x0000_0100, cout=0, ovf=0, zero=0.
- Subtract 5 − 7 -> result=0xFFFF_FFFE, cout=0 (borrow), ovf=0. Subtract 7 − 5 -> result=0x2, cout=1.
- Cross-segment carry: 0xFFFF_FFFF + 0x1 -> result=0, cout=1, zero=1, ovf=0. This exercises all 3 registered carries.
- Overflow: 0x7FFF_FFFF + 1 with sat=0 -> 0x8000_0000, ovf=1. The same beat with sat=1 -> 0x7FFF_FFFF, ovf=1. 0x8000_0000 − 1 with sat=1 -> 0x8000_0000, ovf=1.
- Backpressure: 8 back-to-back beats, out_ready=0 for cycles 5–7. Required:
  - in_ready=0 during the stall;
  - result stable while stalled;
  - all 8 results emerge in order with no loss or duplication;
  - a scoreboard model matches every beat.
- Reset mid-flight: assert rst for 1 cycle with 3 beats in flight. Required:
  - out_valid=0 and result, cout, ovf, zero all 0 in the next cycle;
  - none of the 3 beats ever appears;
  - a new beat issued after reset returns a correct result 4 cycles later.
